door_input_conditioner: RTL

Conditions the raw door sensor and limit-switch inputs before they reach the door controller. Every channel is synchronised and debounced. The person sensors are stretched by a hold-open interval, and the manual-open input is turned into a clean single-cycle pulse for the manual-attempt counter. The block also flags physically impossible limit-switch combinations. It sits directly upstream of the door controller top level, and its outputs drive that level's `pa`, `pp`, `mo`, `r`, `l` and `M` inputs.

---
 rtl/door_input_conditioner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/door_input_conditioner.sv
// -----------------------------------------------------------------------------
// door_input_conditioner
//
// Cleans up the raw door sensors and limit switches before they reach the
// door controller. Each of the six channels is synchronised (two flops) and
// debounced (a change is accepted after DB_CYCLES consecutive differing
// samples). The person sensors pa/pp are held high for HOLD_CYCLES after their
// debounced value falls. The manual-open level also yields a one-cycle pulse
// per debounced press. Any two limit switches active together latch a sticky
// fault until reset.
//
// Ports
//   clk                     : single clock, rising edge
//   reset                   : synchronous, active-high
//   pa_raw, pp_raw, mo_raw  : raw person-approaching / person-present /
//                             manual-open inputs (asynchronous)
//   r_raw, l_raw, M_raw     : raw right / left / middle limit switches
//                             (asynchronous)
//   pa, pp                  : debounced, hold-stretched person signals
//   mo                      : debounced manual-open level
//   mo_pulse                : one-cycle pulse per debounced rising edge of mo
//   r, l, M                 : debounced limit switches
//   fault                   : sticky limit-switch conflict flag
// -----------------------------------------------------------------------------
module door_input_conditioner #(
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pa_raw,
  input  logic pp_raw,
  input  logic mo_raw,
  input  logic r_raw,
  input  logic l_raw,
  input  logic M_raw,
  output logic pa,
  output logic pp,
  output logic mo,
  output logic mo_pulse,
  output logic r,
  output logic l,
  output logic M,
  output logic fault
);

  // Channel numbering used for all per-channel vectors.
  localparam int CH_PA = 0;
  localparam int CH_PP = 1;
  localparam int CH_MO = 2;
  localparam int CH_R  = 3;
  localparam int CH_L  = 4;
  localparam int CH_M  = 5;
  localparam int N_CH  = 6;

  localparam logic [7:0] DB_LAST  = 8'(DB_CYCLES - 1);
  localparam logic [7:0] HOLD_VAL = 8'(HOLD_CYCLES);

  logic [N_CH-1:0] w_raw;
  logic [N_CH-1:0] r_s1;
  logic [N_CH-1:0] r_s2;
  logic [N_CH-1:0] r_d;
  logic [7:0]      r_cnt [N_CH];

  logic [7:0] r_t_pa;
  logic [7:0] r_t_pp;
  logic       r_d_mo_q;
  logic       r_mo_pulse;
  logic       r_fault;
  logic       w_conflict;

  assign w_raw = {M_raw, l_raw, r_raw, mo_raw, pp_raw, pa_raw};

  // Two-flop synchroniser; only s2 feeds the debouncer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce: any sample equal to the current value restarts the count, so
  // only an unbroken run of DB_CYCLES differing samples flips the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_s2[i] == r_d[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_d[i]   <= r_s2[i];
          r_cnt[i] <= 8'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Hold-open timers: reloaded while the debounced value is high, so a
  // re-assertion during the hold keeps the stretched output continuous.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t_pa <= 8'd0;
      r_t_pp <= 8'd0;
    end else begin
      if (r_d[CH_PA]) begin
        r_t_pa <= HOLD_VAL;
      end else if (r_t_pa != 8'd0) begin
        r_t_pa <= r_t_pa - 8'd1;
      end

      if (r_d[CH_PP]) begin
        r_t_pp <= HOLD_VAL;
      end else if (r_t_pp != 8'd0) begin
        r_t_pp <= r_t_pp - 8'd1;
      end
    end
  end

  // Manual-open edge detector and sticky limit-conflict flag.
  assign w_conflict = (r_d[CH_R] & r_d[CH_M]) |
                      (r_d[CH_L] & r_d[CH_M]) |
                      (r_d[CH_R] & r_d[CH_L]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_mo_q   <= 1'b0;
      r_mo_pulse <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_d_mo_q   <= r_d[CH_MO];
      r_mo_pulse <= r_d[CH_MO] & ~r_d_mo_q;
      r_fault    <= r_fault | w_conflict;
    end
  end

  assign pa       = r_d[CH_PA] | (r_t_pa != 8'd0);
  assign pp       = r_d[CH_PP] | (r_t_pp != 8'd0);
  assign mo       = r_d[CH_MO];
  assign mo_pulse = r_mo_pulse;
  assign r        = r_d[CH_R];
  assign l        = r_d[CH_L];
  assign M        = r_d[CH_M];
  assign fault    = r_fault;

endmodule
